// File: rtl/uart_tx_sched.sv
// Four-requester round-robin scheduler feeding a single 8N1 UART transmitter.
// A grant latches the winner's byte and drops Tx on the same edge that pulses ack.
module uart_tx_sched #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        Tx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  gid_q, gid_d;
    logic [3:0]  ack_q, ack_d;
    logic [3:0]  done_q, done_d;
    logic        busy_q, busy_d;
    logic        tx_q, tx_d;

    logic        gnt_vld;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand;
    logic        bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // Scan from the farthest offset down so the one closest to ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        ack_d   = 4'd0;
        done_d  = 4'd0;
        busy_d  = busy_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (gnt_vld) begin
                    sh_d           = req_data[8*gnt_idx +: 8];
                    gid_d          = gnt_idx;
                    ack_d[gnt_idx] = 1'b1;
                    ptr_d          = gnt_idx + 2'd1;
                    tx_d           = 1'b0;
                    busy_d         = 1'b1;
                    cnt_d          = 16'd0;
                    bit_d          = 3'd0;
                    state_d        = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    tx_d    = sh_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift right and present the next LSB in one step.
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d         = 16'd0;
                    tx_d          = 1'b1;
                    busy_d        = 1'b0;
                    done_d[gid_q] = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            ptr_q   <= 2'd0;
            gid_q   <= 2'd0;
            ack_q   <= 4'd0;
            done_q  <= 4'd0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;
    assign Tx       = tx_q;

endmodule
